// File: rtl/bus_fifo_slave.sv
// Register-mapped 8x32 FIFO slave: DATA/STATUS/COUNT/CONTROL at offsets 0..3.
// Define SLAVE_IRQ_EN to build in the threshold interrupt (irq_en/threshold in CONTROL).
module bus_fifo_slave (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        s_interrupt
);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_COUNT  = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  reg_e        offset;
  logic [31:0] mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic        ovf_sticky;
  logic        udf_sticky;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        ctrl_wr;
  logic        rd_access;
  logic        irq_pending;
  logic [4:0]  ctrl_rdata;
  logic [31:0] rdata;
  logic        unused_addr_hi;

  assign offset         = reg_e'(S_address[1:0]);
  assign unused_addr_hi = ^S_address[7:2];
  assign full           = (count == 4'd8);
  assign empty          = (count == 4'd0);
  assign push           = S_sel &&  S_wr && (offset == REG_DATA);
  assign pop            = S_sel && !S_wr && (offset == REG_DATA);
  assign ctrl_wr        = S_sel &&  S_wr && (offset == REG_CTRL);
  assign rd_access      = S_sel && !S_wr;

`ifdef SLAVE_IRQ_EN
  logic       irq_en;
  logic [3:0] threshold;

  // count never exceeds 8, so thresholds 9..15 can never be reached
  assign irq_pending = irq_en && (threshold != 4'd0) && (count >= threshold);
  assign ctrl_rdata  = {threshold, irq_en};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en    <= 1'b0;
      threshold <= '0;
    end else if (ctrl_wr) begin
      irq_en    <= S_din[0];
      threshold <= S_din[4:1];
    end
  end
`else
  assign irq_pending = 1'b0;
  assign ctrl_rdata  = '0;
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      REG_DATA:   rdata = empty ? '0 : mem[rd_ptr];
      REG_STATUS: rdata = {27'd0, irq_pending, udf_sticky, ovf_sticky, full, empty};
      REG_COUNT:  rdata = {28'd0, count};
      REG_CTRL:   rdata = {27'd0, ctrl_rdata};
      default:    rdata = '0;
    endcase
  end

  // Storage is deliberately unreset; the empty check keeps stale words hidden.
  always_ff @(posedge clk) begin
    if (reset_n && push && !full)
      mem[wr_ptr] <= S_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf_sticky  <= 1'b0;
      udf_sticky  <= 1'b0;
      S_dout      <= '0;
      s_interrupt <= 1'b0;
    end else begin
      S_dout      <= rd_access ? rdata : '0;
      s_interrupt <= irq_pending;
      if (ctrl_wr && S_din[5]) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
        udf_sticky <= 1'b0;
      end else if (push) begin
        if (full) begin
          ovf_sticky <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 3'd1;
          count  <= count + 4'd1;
        end
      end else if (pop) begin
        if (empty) begin
          udf_sticky <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 3'd1;
          count  <= count - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Randomized bench for bus_fifo_slave against a queue-based register model.
// Follows SLAVE_IRQ_EN the same way the design does.
module tb_bus_fifo_slave;

  logic        clk;
  logic        reset_n;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S_dout;
  logic        s_interrupt;

  bus_fifo_slave dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .S_sel       (S_sel),
    .S_wr        (S_wr),
    .S_address   (S_address),
    .S_din       (S_din),
    .S_dout      (S_dout),
    .s_interrupt (s_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] q[$];
  bit          m_ovf;
  bit          m_udf;
  bit          m_irq_en;
  bit   [3:0]  m_thr;
  logic        exp_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pending();
`ifdef SLAVE_IRQ_EN
    return m_irq_en && (m_thr != 4'd0) && (q.size() >= int'(m_thr));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (q.size() == 0) ? 32'd0 : q[0];
      2'd1:    return {27'd0, m_pending(), m_udf, m_ovf, q.size() == 8, q.size() == 0};
      2'd2:    return 32'(q.size());
`ifdef SLAVE_IRQ_EN
      default: return {27'd0, m_thr, m_irq_en};
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_irq_en = 1'b0;
    m_thr    = '0;
    exp_irq  = 1'b0;
  endtask

  // Model one clock edge; the interrupt output reflects pending from before the edge.
  task automatic m_step(input bit sel, input bit wr, input logic [1:0] a,
                        input logic [31:0] din, output logic [31:0] exp_dout);
    exp_irq  = m_pending();
    exp_dout = 32'd0;
    if (sel && !wr) begin
      exp_dout = m_read(a);
      if (a == 2'd0) begin
        if (q.size() == 0) m_udf = 1'b1;
        else void'(q.pop_front());
      end
    end else if (sel && wr) begin
      if (a == 2'd0) begin
        if (q.size() == 8) m_ovf = 1'b1;
        else q.push_back(din);
      end else if (a == 2'd3) begin
        if (din[5]) begin
          q.delete();
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
        m_irq_en = din[0];
        m_thr    = din[4:1];
      end
    end
  endtask

  task automatic cycle(input bit sel, input bit wr, input logic [1:0] a, input logic [31:0] din);
    logic [31:0] exp_dout;
    @(negedge clk);
    S_sel     = sel;
    S_wr      = wr;
    S_address = {6'($urandom), a};
    S_din     = din;
    @(posedge clk);
    #1;
    m_step(sel, wr, a, din, exp_dout);
    check($sformatf("dout sel%0d wr%0d a%0d", sel, wr, a), S_dout, exp_dout);
    check("irq", {31'd0, s_interrupt}, {31'd0, exp_irq});
    S_sel = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d); cycle(1'b1, 1'b1, a, d); endtask
  task automatic rd_reg(input logic [1:0] a); cycle(1'b1, 1'b0, a, 32'd0); endtask
  task automatic idle(); cycle(1'b0, 1'($urandom), 2'($urandom), $urandom); endtask

  initial begin
    int unsigned r;
    logic [31:0] d;
    reset_n   = 1'b0;
    S_sel     = 1'b0;
    S_wr      = 1'b0;
    S_address = '0;
    S_din     = '0;
    m_reset();
    #2;
    check("reset dout", S_dout, 32'd0);
    check("reset irq", {31'd0, s_interrupt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // fill, read COUNT/STATUS, drain in order
    for (int i = 1; i <= 8; i++) wr_reg(2'd0, 32'h1111_1111 * i);
    rd_reg(2'd2);
    rd_reg(2'd1);
    for (int i = 0; i < 8; i++) rd_reg(2'd0);
    rd_reg(2'd1);

    // overflow drops the extra word
    for (int i = 1; i <= 8; i++) wr_reg(2'd0, 32'h1111_1111 * i);
    wr_reg(2'd0, 32'hDEAD_BEEF);
    rd_reg(2'd1);
    for (int i = 0; i < 8; i++) rd_reg(2'd0);

    // underflow, then clear
    rd_reg(2'd0);
    rd_reg(2'd1);
    wr_reg(2'd3, 32'h20);
    rd_reg(2'd1);

    // threshold interrupt
    wr_reg(2'd3, 32'h07);
    rd_reg(2'd3);
    for (int i = 0; i < 3; i++) wr_reg(2'd0, $urandom);
    idle();
    idle();
    rd_reg(2'd1);
    rd_reg(2'd0);
    idle();
    idle();
    wr_reg(2'd3, 32'h20);

    // pointer wrap-around
    for (int i = 0; i < 6; i++) wr_reg(2'd0, $urandom);
    for (int i = 0; i < 6; i++) rd_reg(2'd0);
    for (int i = 0; i < 5; i++) wr_reg(2'd0, $urandom);
    for (int i = 0; i < 5; i++) rd_reg(2'd0);
    rd_reg(2'd2);

    // random traffic, including writes to read-only offsets and odd thresholds
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      wr_reg(2'd0, $urandom);
      else if (r < 72) rd_reg(2'd0);
      else if (r < 84) rd_reg(2'($urandom_range(1, 3)));
      else if (r < 91) begin
        d = $urandom;
        d[5] = ($urandom_range(0, 3) == 0);
        wr_reg(2'd3, d);
      end
      else if (r < 95) wr_reg(2'($urandom_range(1, 2)), $urandom);
      else             idle();
    end

    // asynchronous reset between edges
    wr_reg(2'd3, 32'h27);
    for (int i = 0; i < 4; i++) wr_reg(2'd0, 32'hA000_0000 + i);
    rd_reg(2'd2);
    check("pre-reset count", S_dout, 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async dout", S_dout, 32'd0);
    check("async irq", {31'd0, s_interrupt}, 32'd0);
    check("async count", {28'd0, dut.count}, 32'd0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(2'd2);
    rd_reg(2'd3);
    wr_reg(2'd0, 32'h5A5A_0001);
    rd_reg(2'd0);
    rd_reg(2'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
